data_mem_unit: RTL



---
 rtl/riscv_mem_pkg.sv | 42 ++++
 rtl/mem_lane_align.sv | 39 +++
 rtl/data_mem_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the access legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // True when the request cannot be serviced: both strobes high, a funct3
  // not defined for the request type, or an address not aligned to its size.
  function automatic logic access_illegal(input logic       mem_read,
                                          input logic       mem_write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] byte_off);
    logic bad_f3;
    logic misaligned;
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    if (mem_read && mem_write) begin
      bad_f3 = 1'b1;
    end else if (mem_read) begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end else if (mem_write) begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    end
    case (funct3)
      F3_H, F3_HU: misaligned = byte_off[0];
      F3_W:        misaligned = |byte_off;
      default:     misaligned = 1'b0;
    endcase
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges store data into the addressed word and
// extracts/extends load data from it.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    sel_byte   = word[{byte_off, 3'b000} +: 8];
    sel_half   = byte_off[1] ? word[31:16] : word[15:0];
    store_word = word;
    load_data  = word;

    case (funct3)
      F3_B:    store_word[{byte_off, 3'b000} +: 8]  = wdata[7:0];
      F3_H:    store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase

    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory responder: services one load/store per instruction against a
// fixed-latency word RAM, stalling the core until the access completes.
module data_mem_unit
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   cap_idx;
  logic [1:0]      cap_off;
  logic [31:0]     cap_wdata;
  logic [2:0]      cap_f3;
  logic            cap_store;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            illegal;
  logic            legal_req;
  logic            enter_done;
  logic [AW-1:0]   acc_idx;
  logic [1:0]      acc_off;
  logic [31:0]     acc_wdata;
  logic [2:0]      acc_f3;
  logic            acc_store;
  logic [31:0]     old_word;
  logic [31:0]     store_word;
  logic [31:0]     load_data;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^addr[31:AW+2];

  assign req       = MemRead || MemWrite;
  assign illegal   = access_illegal(MemRead, MemWrite, funct3, addr[1:0]);
  assign legal_req = (state == IDLE) && req && !illegal;
  assign err       = (state == IDLE) && req && illegal;
  assign stall     = legal_req || (state == BUSY);

  // With LATENCY=1 the access completes straight out of IDLE, so the live
  // inputs drive the RAM instead of the not-yet-captured copies.
  assign enter_done = (legal_req && (LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == CW'(1)));
  assign acc_idx    = (state == IDLE) ? addr[AW+1:2] : cap_idx;
  assign acc_off    = (state == IDLE) ? addr[1:0]    : cap_off;
  assign acc_wdata  = (state == IDLE) ? wdata        : cap_wdata;
  assign acc_f3     = (state == IDLE) ? funct3       : cap_f3;
  assign acc_store  = (state == IDLE) ? MemWrite     : cap_store;
  assign old_word   = mem[acc_idx];

  mem_lane_align u_align (
    .word       (old_word),
    .wdata      (acc_wdata),
    .funct3     (acc_f3),
    .byte_off   (acc_off),
    .store_word (store_word),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      cap_idx   <= '0;
      cap_off   <= '0;
      cap_wdata <= '0;
      cap_f3    <= '0;
      cap_store <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (legal_req) begin
            cap_idx   <= addr[AW+1:2];
            cap_off   <= addr[1:0];
            cap_wdata <= wdata;
            cap_f3    <= funct3;
            cap_store <= MemWrite;
            cnt       <= CNT_LOAD;
            state     <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enter_done && !acc_store) rdata <= load_data;
    end
  end

  // NOTE: the RAM array is deliberately left out of reset; only the write
  // enable is gated so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!reset && enter_done && acc_store) mem[acc_idx] <= store_word;
  end

endmodule
